alu_req_sched: RTL

- Two-requester scheduler that shares one 16-bit combinational ALU (5-bit opcode, 16-bit result, 4-bit flags {parity, overflow, zero, carry}).
- Arbitrates round-robin, registers the granted operands onto the ALU inputs and captures the result.
- Owns the architectural flag register: applies update / clear / keep semantics per opcode class.
- Returns one response per accepted request through a valid/ready handshake.

---
 rtl/alu_pkg.sv | 55 +++++
 rtl/rr_arb2.sv | 36 +++
 rtl/alu_req_sched.sv | 129 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU request scheduler: opcodes, flag bit
// positions, opcode classes and the class decoder.
package alu_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned OPW   = 5;

    localparam logic [OPW-1:0] OP_ADD  = 5'b00000;
    localparam logic [OPW-1:0] OP_ADC  = 5'b00001;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00010;
    localparam logic [OPW-1:0] OP_AND  = 5'b00100;
    localparam logic [OPW-1:0] OP_OR   = 5'b00101;
    localparam logic [OPW-1:0] OP_XOR  = 5'b00110;
    localparam logic [OPW-1:0] OP_NOT  = 5'b00111;
    localparam logic [OPW-1:0] OP_CLR  = 5'b10000;
    localparam logic [OPW-1:0] OP_CLRF = 5'b10001;
    localparam logic [OPW-1:0] OP_MOV  = 5'b10100;
    localparam logic [OPW-1:0] OP_MOVB = 5'b10101;
    localparam logic [OPW-1:0] OP_NOP  = 5'b10111;
    localparam logic [OPW-1:0] OP_LD   = 5'b11000;
    localparam logic [OPW-1:0] OP_SHL  = 5'b11001;
    localparam logic [OPW-1:0] OP_SHR  = 5'b11010;
    localparam logic [OPW-1:0] OP_ASR  = 5'b11011;

    localparam int unsigned PAR = 3;
    localparam int unsigned OVF = 2;
    localparam int unsigned ZER = 1;
    localparam int unsigned CAR = 0;

    typedef enum logic [1:0] {
        ClsUpdate,
        ClsClear,
        ClsKeep,
        ClsIllegal
    } op_class_e;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    function automatic op_class_e op_class(input logic [OPW-1:0] op);
        op_class_e cls;
        case (op)
            OP_ADD, OP_ADC, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_SHL, OP_SHR, OP_ASR:         cls = ClsUpdate;
            OP_CLR, OP_CLRF:                cls = ClsClear;
            OP_MOV, OP_MOVB, OP_NOP, OP_LD: cls = ClsKeep;
            default:                        cls = ClsIllegal;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; priority flips to the other requester after
// every accepted grant.
module rr_arb2 #(
    parameter bit RR_INIT = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic valid0,
    input  logic valid1,
    input  logic advance,
    output logic grant,
    output logic gnt_valid
);

    logic prio_q;

    always_comb begin
        grant = 1'b0;
        if (valid0 && valid1) begin
            grant = prio_q;
        end else if (valid1) begin
            grant = 1'b1;
        end
    end

    assign gnt_valid = valid0 | valid1;

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= RR_INIT;
        end else if (advance) begin
            prio_q <= ~grant;
        end
    end

endmodule

// File: rtl/alu_req_sched.sv
// Schedules two requesters onto one shared combinational ALU, owns the
// architectural flag register and returns one response per accepted request.
module alu_req_sched
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = alu_pkg::WIDTH,
    parameter int unsigned OPW     = alu_pkg::OPW,
    parameter bit          RR_INIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [OPW-1:0]   req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [OPW-1:0]   req1_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [OPW-1:0]   alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [3:0]       flag_q,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             grant, gnt_valid, accept;
    logic [WIDTH-1:0] sel_a, sel_b;
    logic [OPW-1:0]   sel_op;
    op_class_e        sel_cls, exec_cls;
    logic             id_q, err_q;
    logic [WIDTH-1:0] res_q;

    assign accept = (state_q == StIdle) && gnt_valid;

    rr_arb2 #(
        .RR_INIT(RR_INIT)
    ) u_arb (
        .clk      (clk),
        .reset    (reset),
        .valid0   (req0_valid),
        .valid1   (req1_valid),
        .advance  (accept),
        .grant    (grant),
        .gnt_valid(gnt_valid)
    );

    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;

    assign sel_a   = grant ? req1_a : req0_a;
    assign sel_b   = grant ? req1_b : req0_b;
    assign sel_op  = grant ? req1_op : req0_op;
    assign sel_cls = op_class(sel_op);
    // Only legal ops reach EXEC, so the registered ALU opcode is the captured op.
    assign exec_cls = op_class(alu_opcode);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = (sel_cls == ClsIllegal) ? StResp : StExec;
                end
            end
            StExec: state_d = StResp;
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            flag_q     <= '0;
            res_q      <= '0;
            id_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                id_q <= grant;
                if (sel_cls == ClsIllegal) begin
                    err_q <= 1'b1;
                    res_q <= '0;
                end else begin
                    err_q      <= 1'b0;
                    alu_a      <= sel_a;
                    alu_b      <= sel_b;
                    alu_opcode <= sel_op;
                end
            end
            if (state_q == StExec) begin
                res_q <= (exec_cls == ClsClear) ? '0 : alu_result;
                case (exec_cls)
                    ClsUpdate: flag_q <= alu_flags;
                    ClsClear:  flag_q <= '0;
                    default:   flag_q <= flag_q;
                endcase
            end
        end
    end

    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = id_q;
    assign rsp_result = res_q;
    assign rsp_flags  = flag_q;
    assign rsp_err    = err_q;
    assign busy       = (state_q != StIdle);

endmodule
